// File: rtl/led_hold_pkg.sv
// Shared types and width helpers for the multi-channel LED hold controller.
package led_hold_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BLINK = 2'd2
  } led_state_t;

  // Hold counter width: enough bits to hold HOLD_CYCLES-1, never narrower than 1.
  function automatic int calc_hcw(input int hold_cycles);
    int w;
    w = $clog2(hold_cycles);
    return (w < 1) ? 1 : w;
  endfunction

  // Blink phase counter width: enough bits to hold BLINK_HALF-1, never narrower than 1.
  function automatic int calc_bcw(input int blink_half);
    int w;
    w = $clog2(blink_half);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_hold_chan.sv
// One LED channel: IDLE/HOLD(/BLINK) FSM with hold counter and, when
// LED_HOLD_BLINK_EN is defined, a blink phase counter. All outputs registered.
module led_hold_chan
  import led_hold_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int BLINK_HALF  = 2
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_trig,
  input  logic i_clr,
  input  logic i_mode,
  output logic o_led,
  output logic o_busy,
  output logic o_done
);

  localparam int HCW = calc_hcw(HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  led_state_t     r_state;
  logic [HCW-1:0] r_hold_cnt;
  logic           r_led;
  logic           r_busy;
  logic           r_done;
  led_state_t     w_trig_state;

`ifdef LED_HOLD_BLINK_EN
  localparam int BCW = calc_bcw(BLINK_HALF);
  localparam logic [BCW-1:0] PHASE_LOAD = BCW'(BLINK_HALF - 1);

  logic [BCW-1:0] r_phase_cnt;

  assign w_trig_state = i_mode ? BLINK : HOLD;
`else
  // Solid-only build: mode is accepted on the port but has no effect.
  localparam int BLINK_HALF_UNUSED = BLINK_HALF;
  logic w_mode_unused;

  assign w_mode_unused = i_mode;
  assign w_trig_state  = HOLD;
`endif

  // Channel FSM: reset, then clr, then trig/retrigger, then countdown and expiry.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef LED_HOLD_BLINK_EN
      r_phase_cnt <= '0;
`endif
    end else if (i_clr) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef LED_HOLD_BLINK_EN
      r_phase_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, HOLD, BLINK: begin
          if (i_trig) begin
            // Start or extend: reload the window and restart the pattern lit.
            r_state    <= w_trig_state;
            r_hold_cnt <= HOLD_LOAD;
            r_led      <= 1'b1;
            r_busy     <= 1'b1;
`ifdef LED_HOLD_BLINK_EN
            r_phase_cnt <= PHASE_LOAD;
`endif
          end else if (r_state == IDLE) begin
            r_led  <= 1'b0;
            r_busy <= 1'b0;
          end else if (r_hold_cnt == '0) begin
            // Natural expiry: LED off and done pulse on the same edge busy falls.
            r_state <= IDLE;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt - HCW'(1);
`ifdef LED_HOLD_BLINK_EN
            if (r_state == BLINK) begin
              if (r_phase_cnt == '0) begin
                r_led       <= ~r_led;
                r_phase_cnt <= PHASE_LOAD;
              end else begin
                r_phase_cnt <= r_phase_cnt - BCW'(1);
              end
            end else begin
              r_led <= 1'b1;
            end
`else
            r_led <= 1'b1;
`endif
          end
        end
        default: begin
          r_state    <= IDLE;
          r_hold_cnt <= '0;
          r_led      <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_led  = r_led;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/led_hold_ctrl.sv
// Multi-channel LED hold controller: NUM_CH independent led_hold_chan instances.
// Blink support is compiled in when LED_HOLD_BLINK_EN is defined.
module led_hold_ctrl
  import led_hold_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int BLINK_HALF  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] clr,
  input  logic [NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0] LED,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    led_hold_chan #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .BLINK_HALF  (BLINK_HALF)
    ) u_chan (
      .clk     (clk),
      .i_reset (reset),
      .i_trig  (trig[g]),
      .i_clr   (clr[g]),
      .i_mode  (mode[g]),
      .o_led   (LED[g]),
      .o_busy  (busy[g]),
      .o_done  (done[g])
    );
  end

endmodule

// File: tb/tb_led_hold_ctrl.sv
// Randomized + directed bench for led_hold_ctrl with a scoreboard queue.
// The reference model tracks remaining hold time and elapsed time per channel.
module tb_led_hold_ctrl;

  localparam int NUM_CH      = 4;
  localparam int HOLD_CYCLES = 10;
  localparam int BLINK_HALF  = 2;
  localparam int EW          = 3 * NUM_CH;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] LED;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;

  led_hold_ctrl #(
    .NUM_CH      (NUM_CH),
    .HOLD_CYCLES (HOLD_CYCLES),
    .BLINK_HALF  (BLINK_HALF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .trig  (trig),
    .clr   (clr),
    .mode  (mode),
    .LED   (LED),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: remaining lit cycles and cycles since last (re)trigger.
  int          m_rem   [NUM_CH];
  int          m_el    [NUM_CH];
  bit          m_blink [NUM_CH];
  logic [EW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  bit driving_done = 1'b0;

`ifdef LED_HOLD_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  // Apply one cycle of inputs, advance the model, and queue the expected outputs.
  task automatic drive(input logic [NUM_CH-1:0] t, input logic [NUM_CH-1:0] c,
                       input logic [NUM_CH-1:0] m, input logic r);
    logic [NUM_CH-1:0] e_led, e_busy, e_done;
    @(negedge clk);
    trig  = t;
    clr   = c;
    mode  = m;
    reset = r;
    for (int i = 0; i < NUM_CH; i++) begin
      e_done[i] = 1'b0;
      if (!r || c[i]) begin
        m_rem[i] = 0;
      end else if (t[i]) begin
        m_rem[i]   = HOLD_CYCLES;
        m_el[i]    = 0;
        m_blink[i] = BLINK_ON && m[i];
      end else if (m_rem[i] > 0) begin
        m_rem[i] = m_rem[i] - 1;
        m_el[i]  = m_el[i] + 1;
        if (m_rem[i] == 0) e_done[i] = 1'b1;
      end
      e_busy[i] = (m_rem[i] > 0);
      if (m_rem[i] == 0) e_led[i] = 1'b0;
      else if (m_blink[i]) e_led[i] = ((m_el[i] / BLINK_HALF) % 2) == 0;
      else e_led[i] = 1'b1;
    end
    exp_q.push_back({e_led, e_busy, e_done});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive('0, '0, '0, 1'b1);
  endtask

  // Monitor: after each edge, pop one expected entry and compare with the DUT.
  initial begin
    logic [EW-1:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v  = exp_q.pop_front();
        checks = checks + 1;
        if ({LED, busy, done} !== exp_v) begin
          errors = errors + 1;
          $display("FAIL outputs t=%0t LED/busy/done got %b/%b/%b want %b/%b/%b", $time,
                   LED, busy, done, exp_v[EW-1 -: NUM_CH], exp_v[2*NUM_CH-1 -: NUM_CH],
                   exp_v[NUM_CH-1:0]);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by a long randomized run.
  initial begin
    logic [NUM_CH-1:0] rt, rc, rm;
    logic              rr;
    for (int i = 0; i < NUM_CH; i++) begin
      m_rem[i] = 0; m_el[i] = 0; m_blink[i] = 1'b0;
    end
    trig = '0; clr = '0; mode = '0; reset = 1'b0;

    drive('0, '0, '0, 1'b0);
    drive('0, '0, '0, 1'b0);
    idle(20);
    // Single solid trigger on channel 0.
    drive(4'b0001, '0, '0, 1'b1);
    idle(14);
    // Retrigger mid-window on channel 1, then retrigger on the final count.
    drive(4'b0010, '0, '0, 1'b1);
    idle(6);
    drive(4'b0010, '0, '0, 1'b1);
    idle(14);
    drive(4'b0010, '0, '0, 1'b1);
    idle(HOLD_CYCLES - 1);
    drive(4'b0010, '0, '0, 1'b1);
    idle(14);
    // Blink request on channel 2.
    drive(4'b0100, '0, 4'b0100, 1'b1);
    idle(14);
    // Clear wins over trig on channel 3.
    drive(4'b1000, '0, '0, 1'b1);
    idle(2);
    drive(4'b1000, 4'b1000, '0, 1'b1);
    idle(4);
    drive('0, 4'b1000, '0, 1'b1);
    // Reset mid-hold on channel 0.
    drive(4'b0001, '0, '0, 1'b1);
    idle(4);
    drive('0, '0, '0, 1'b0);
    idle(3);
    // Staggered triggers with mixed modes.
    drive(4'b0001, '0, 4'b0000, 1'b1);
    drive(4'b0010, '0, 4'b0010, 1'b1);
    drive(4'b0100, '0, 4'b0000, 1'b1);
    drive(4'b1000, '0, 4'b1000, 1'b1);
    idle(15);
    // Mode switch on retrigger.
    drive(4'b0001, '0, 4'b0001, 1'b1);
    idle(3);
    drive(4'b0001, '0, 4'b0000, 1'b1);
    idle(3);
    drive(4'b0001, '0, 4'b0001, 1'b1);
    idle(14);
    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rt[i] = ($urandom_range(0, 11) == 0);
        rc[i] = ($urandom_range(0, 47) == 0);
        rm[i] = $urandom_range(0, 1) != 0;
      end
      rr = ($urandom_range(0, 299) != 0);
      drive(rt, rc, rm, rr);
    end
    idle(2);
    driving_done = 1'b1;
  end

  // Completion: wait for the stimulus with a time bound, drain, then summarize.
  initial begin
    int budget;
    budget = 0;
    while (!driving_done && budget < 20000) begin
      @(posedge clk);
      budget = budget + 1;
    end
    if (!driving_done) begin
      errors = errors + 1;
      $display("FAIL timeout stimulus did not complete within %0d cycles", budget);
    end
    @(posedge clk);
    #2;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain queue has %0d entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
